// File: rtl/pc_redirect_pkg.sv
// pc_redirect shared types and defaults.
// Fetch PC generator state encoding and reset address.
package pc_redirect_pkg;

  localparam int DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

endpackage

// File: rtl/pc_redirect_if.sv
// Fetch request channel between the PC generator
// and the instruction-memory port.
interface pc_redirect_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] pc;
  logic                  pc_valid;
  logic                  if_ready;
  logic                  resp_drop;

  modport master (
    output pc,
    output pc_valid,
    output resp_drop,
    input  if_ready
  );

  modport slave (
    input  pc,
    input  pc_valid,
    input  resp_drop,
    output if_ready
  );
endinterface

// File: rtl/pc_redirect_sat_counter.sv
// Saturating up-counter with synchronous
// active-high reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pc_redirect.sv
// Fetch-side PC generator: advances the PC,
// applies EX redirects and buffers stalled ones.
module pc_redirect
  import pc_redirect_pkg::*;
#(
  parameter int                    DATA_WIDTH = pc_redirect_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = pc_redirect_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  branch_res,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  hold,
  pc_redirect_if.master         fetch,
  output logic                  flush_if_id,
  output logic                  flush_id_ex,
  output logic                  target_misalign,
  output logic [31:0]           redirect_cnt
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic                  drop_q, drop_d;
  logic                  mis_q, mis_d;
  logic                  pc_valid;
  logic                  flush;
  logic                  cnt_en;
  logic [DATA_WIDTH-1:0] aligned;
  logic                  unused_ok;

  // Bit 0 is dropped by the jalr rule.
  assign aligned   = {branch_target[DATA_WIDTH-1:2], 2'b00};
  assign unused_ok = branch_target[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      drop_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      drop_q  <= drop_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    drop_d   = 1'b0;
    mis_d    = 1'b0;
    pc_valid = 1'b0;
    flush    = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
        pc_d    = RESET_PC;
      end
      RUN: begin
        pc_valid = 1'b1;
        flush    = branch_res;
        if (branch_res) begin
          cnt_en = 1'b1;
          mis_d  = branch_target[1];
          if (fetch.if_ready) begin
            pc_d   = aligned;
            drop_d = 1'b1;
          end else begin
            tgt_d   = aligned;
            state_d = PEND;
          end
        end else if (fetch.if_ready && !hold) begin
          pc_d = pc_q + DATA_WIDTH'(4);
        end
      end
      PEND: begin
        pc_valid = 1'b1;
        flush    = branch_res;
        if (branch_res) begin
          cnt_en = 1'b1;
          mis_d  = branch_target[1];
          tgt_d  = aligned;
        end
        // A same-cycle redirect overrides the buffered one.
        if (fetch.if_ready) begin
          pc_d    = branch_res ? aligned : tgt_q;
          drop_d  = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
        pc_d    = RESET_PC;
      end
    endcase
  end

  sat_counter #(
    .WIDTH(32)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .count(redirect_cnt)
  );

  assign fetch.pc        = pc_q;
  assign fetch.pc_valid  = pc_valid;
  assign fetch.resp_drop = drop_q;
  assign flush_if_id     = flush;
  assign flush_id_ex     = flush;
  assign target_misalign = mis_q;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed table-driven bench for pc_redirect.
// Covers boot, advance, redirects, PEND, hold, misalign, reset.
module tb_pc_redirect;
  import pc_redirect_pkg::*;

  logic        clk;
  logic        rst;
  logic        branch_res;
  logic [31:0] branch_target;
  logic        hold;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        target_misalign;
  logic [31:0] redirect_cnt;

  int checks = 0;
  int errors = 0;

  pc_redirect_if #(.DATA_WIDTH(32)) fif ();

  pc_redirect #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .branch_res     (branch_res),
    .branch_target  (branch_target),
    .hold           (hold),
    .fetch          (fif),
    .flush_if_id    (flush_if_id),
    .flush_id_ex    (flush_id_ex),
    .target_misalign(target_misalign),
    .redirect_cnt   (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        hold;
    logic        rdy;
    logic        flush;
    logic [31:0] pc;
    logic        valid;
    logic        drop;
    logic        mis;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs [24];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic post_chk(input string tag, input logic [31:0] pc,
                          input logic valid, input logic drop,
                          input logic mis, input logic [31:0] cnt);
    chk({tag, " pc"}, fif.pc, pc);
    chk({tag, " pc_valid"}, 32'(fif.pc_valid), 32'(valid));
    chk({tag, " resp_drop"}, 32'(fif.resp_drop), 32'(drop));
    chk({tag, " misalign"}, 32'(target_misalign), 32'(mis));
    chk({tag, " cnt"}, redirect_cnt, cnt);
  endtask

  initial begin
    //          br  tgt           hld rdy fl  pc            v  drp mis cnt
    vecs[0]  = '{1, 32'h500,      0, 1, 0, 32'h0,        1, 0, 0, 0};
    vecs[1]  = '{0, 32'h0,        0, 1, 0, 32'h4,        1, 0, 0, 0};
    vecs[2]  = '{0, 32'h0,        0, 1, 0, 32'h8,        1, 0, 0, 0};
    vecs[3]  = '{1, 32'h100,      0, 1, 1, 32'h100,      1, 1, 0, 1};
    vecs[4]  = '{0, 32'h0,        0, 1, 0, 32'h104,      1, 0, 0, 1};
    vecs[5]  = '{1, 32'h200,      0, 0, 1, 32'h104,      1, 0, 0, 2};
    vecs[6]  = '{0, 32'h0,        0, 0, 0, 32'h104,      1, 0, 0, 2};
    vecs[7]  = '{0, 32'h0,        1, 0, 0, 32'h104,      1, 0, 0, 2};
    vecs[8]  = '{0, 32'h0,        0, 1, 0, 32'h200,      1, 1, 0, 2};
    vecs[9]  = '{0, 32'h0,        0, 1, 0, 32'h204,      1, 0, 0, 2};
    vecs[10] = '{1, 32'h200,      0, 0, 1, 32'h204,      1, 0, 0, 3};
    vecs[11] = '{1, 32'h300,      0, 0, 1, 32'h204,      1, 0, 0, 4};
    vecs[12] = '{0, 32'h0,        0, 1, 0, 32'h300,      1, 1, 0, 4};
    vecs[13] = '{0, 32'h0,        0, 1, 0, 32'h304,      1, 0, 0, 4};
    vecs[14] = '{0, 32'h0,        1, 1, 0, 32'h304,      1, 0, 0, 4};
    vecs[15] = '{0, 32'h0,        1, 1, 0, 32'h304,      1, 0, 0, 4};
    vecs[16] = '{1, 32'h40,       1, 1, 1, 32'h40,       1, 1, 0, 5};
    vecs[17] = '{0, 32'h0,        0, 1, 0, 32'h44,       1, 0, 0, 5};
    vecs[18] = '{1, 32'h106,      0, 1, 1, 32'h104,      1, 1, 1, 6};
    vecs[19] = '{0, 32'h0,        0, 1, 0, 32'h108,      1, 0, 0, 6};
    vecs[20] = '{1, 32'h10B,      0, 1, 1, 32'h108,      1, 1, 1, 7};
    vecs[21] = '{0, 32'h0,        0, 0, 0, 32'h108,      1, 0, 0, 7};
    vecs[22] = '{1, 32'hFFFFFFFC, 0, 1, 1, 32'hFFFFFFFC, 1, 1, 0, 8};
    vecs[23] = '{0, 32'h0,        0, 1, 0, 32'h0,        1, 0, 0, 8};

    rst           = 1'b1;
    branch_res    = 1'b0;
    branch_target = '0;
    hold          = 1'b0;
    fif.if_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    post_chk("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset flush", 32'(flush_if_id), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      branch_res    = vecs[i].br;
      branch_target = vecs[i].tgt;
      hold          = vecs[i].hold;
      fif.if_ready  = vecs[i].rdy;
      #1;
      chk($sformatf("v%0d flush_if_id", i), 32'(flush_if_id),
          32'(vecs[i].flush));
      chk($sformatf("v%0d flush_id_ex", i), 32'(flush_id_ex),
          32'(vecs[i].flush));
      @(posedge clk);
      #1;
      post_chk($sformatf("v%0d", i), vecs[i].pc, vecs[i].valid,
               vecs[i].drop, vecs[i].mis, vecs[i].cnt);
    end

    // Reset while a redirect is pending in PEND.
    @(negedge clk);
    branch_res    = 1'b1;
    branch_target = 32'h800;
    fif.if_ready  = 1'b0;
    @(posedge clk);
    #1;
    post_chk("pend", 32'h0, 1'b1, 1'b0, 1'b0, 32'd9);

    @(negedge clk);
    branch_res   = 1'b0;
    rst          = 1'b1;
    fif.if_ready = 1'b1;
    @(posedge clk);
    #1;
    post_chk("rst_pend", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    post_chk("boot2", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

    @(posedge clk);
    #1;
    post_chk("run2", 32'h4, 1'b1, 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
